mips_multicycle_ctrl: RTL

//  Main control FSM for the multicycle MIPS datapath; sequences fetch/decode/execute/mem/writeback.

---
 rtl/mips_ctrl_pkg.sv | 69 ++++++
 rtl/mips_multicycle_ctrl_if.sv | 39 +++
 rtl/mips_ctrl_outdec.sv | 85 ++++++++
 rtl/mips_multicycle_ctrl.sv | 90 +++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS main control FSM.
// Opcodes, state encoding, ALU-op / mux-select codes and the control word.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_SLT   = 2'b11;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REXEC  = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_JUMP   = 4'd12
  } state_e;

  // gate: ir_write/pc_write/done only take effect on a mem_ready cycle
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       ior_d;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       done;
    logic       gate;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_R)    || (op == OP_LW)   ||
           (op == OP_SW)   || (op == OP_BEQ)  ||
           (op == OP_ADDI) || (op == OP_SLTI) ||
           (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between main FSM and multicycle datapath/memory.
// master: FSM side (drives controls); slave: datapath side.
interface mips_ctrl_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       ior_d;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       retire;
  logic       illegal_op;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, mem_write, ior_d,
    output ir_write, reg_write, reg_dst,
    output mem_to_reg, alu_src_a, alu_src_b,
    output alu_op, pc_src, pc_en,
    output retire, illegal_op
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, mem_write, ior_d,
    input  ir_write, reg_write, reg_dst,
    input  mem_to_reg, alu_src_a, alu_src_b,
    input  alu_op, pc_src, pc_en,
    input  retire, illegal_op
  );
endinterface

// File: rtl/mips_ctrl_outdec.sv
// Moore output decoder: state + captured opcode -> control word.
// in: state, opc; out: cw (ungated control word).
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] opc,
  output ctrl_t      cw
);

  always_comb begin
    cw = '0;
    unique case (state)
      S_FETCH: begin
        cw.mem_req   = 1'b1;
        cw.ir_write  = 1'b1;
        cw.pc_write  = 1'b1;
        cw.alu_src_b = SRCB_FOUR;
        cw.alu_op    = ALUOP_ADD;
        cw.pc_src    = PCSRC_ALU;
        cw.gate      = 1'b1;
      end
      S_DECODE: begin
        cw.alu_src_b = SRCB_IMM_SH;
        cw.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        cw.mem_req = 1'b1;
        cw.ior_d   = 1'b1;
      end
      S_MEMWB: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = 1'b1;
        cw.done       = 1'b1;
      end
      S_MEMWR: begin
        cw.mem_req   = 1'b1;
        cw.mem_write = 1'b1;
        cw.ior_d     = 1'b1;
        cw.done      = 1'b1;
        cw.gate      = 1'b1;
      end
      S_REXEC: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_RT;
        cw.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        cw.reg_write = 1'b1;
        cw.reg_dst   = 1'b1;
        cw.done      = 1'b1;
      end
      S_BRANCH: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_RT;
        cw.alu_op    = ALUOP_SUB;
        cw.pc_src    = PCSRC_ALUOUT;
        cw.branch    = 1'b1;
        cw.done      = 1'b1;
      end
      S_IEXEC: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = (opc == OP_SLTI) ?
                       ALUOP_SLT : ALUOP_ADD;
      end
      S_IWB: begin
        cw.reg_write = 1'b1;
        cw.done      = 1'b1;
      end
      S_JUMP: begin
        cw.pc_src   = PCSRC_JUMP;
        cw.pc_write = 1'b1;
        cw.done     = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath.
// Ports: clk, rst_n (async low), bus (mips_ctrl_if.master).
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter bit MEM_HS = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  mips_ctrl_if.master   bus
);

  state_e     state_q, state_d;
  logic [5:0] opc_q, opc_d;
  ctrl_t      cw;
  logic       rdy;
  logic       fire;

  assign rdy = MEM_HS ? bus.mem_ready : 1'b1;

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (rdy) state_d = S_DECODE;
      S_DECODE: begin
        opc_d = bus.opcode;
        unique case (1'b1)
          (bus.opcode == OP_LW),
          (bus.opcode == OP_SW):   state_d = S_MEMADR;
          (bus.opcode == OP_R):    state_d = S_REXEC;
          (bus.opcode == OP_BEQ):  state_d = S_BRANCH;
          (bus.opcode == OP_ADDI),
          (bus.opcode == OP_SLTI): state_d = S_IEXEC;
          (bus.opcode == OP_J):    state_d = S_JUMP;
          default:                 state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opc_q == OP_SW) ?
                          S_MEMWR : S_MEMRD;
      S_MEMRD:  if (rdy) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (rdy) state_d = S_FETCH;
      S_REXEC:  state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
    end
  end

  mips_ctrl_outdec u_outdec (
    .state (state_q),
    .opc   (opc_q),
    .cw    (cw)
  );

  assign fire = ~cw.gate | rdy;

  assign bus.mem_req    = cw.mem_req;
  assign bus.mem_write  = cw.mem_write;
  assign bus.ior_d      = cw.ior_d;
  assign bus.ir_write   = cw.ir_write & fire;
  assign bus.reg_write  = cw.reg_write;
  assign bus.reg_dst    = cw.reg_dst;
  assign bus.mem_to_reg = cw.mem_to_reg;
  assign bus.alu_src_a  = cw.alu_src_a;
  assign bus.alu_src_b  = cw.alu_src_b;
  assign bus.alu_op     = cw.alu_op;
  assign bus.pc_src     = cw.pc_src;
  assign bus.pc_en      = (cw.pc_write & fire) |
                          (cw.branch & bus.zero);
  assign bus.retire     = cw.done & fire;
  assign bus.illegal_op = (state_q == S_DECODE) &
                          ~op_legal(bus.opcode);

endmodule
